// File: rtl/pio_write_arbiter.sv
// pio_write_arbiter
//   Round-robin arbiter that shares the write port of an 8-bit output PIO
//   among NUM_REQ hardware requesters. Each grant becomes one Avalon-MM write
//   of the winner's byte to PIO address 0. The winner gets a one-cycle ack.
//
//   Optional feature macro: PIO_ARB_READBACK_EN
//     When defined, each write is followed by a readback (RDBK) and a compare
//     (CHECK) cycle. The ack is issued in CHECK, and err pulses if the byte
//     read back differs from the byte written.
//
// Ports
//   clk, reset_n    clock, synchronous active-low reset
//   req             per-requester level request, held until ack
//   req_data        packed request bytes, requester i at [i*DATA_W +: DATA_W]
//   ack             one-hot one-cycle pulse to the serviced requester
//   busy            high whenever the FSM is not in IDLE
//   grant_id        index of the current or most recent grant
//   avm_*           Avalon-MM master toward the PIO s1 slave
//   err             readback mismatch pulse (constant 0 without the feature)

module pio_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic [1:0]                  avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [31:0]                 avm_writedata,
  input  logic [31:0]                 avm_readdata,
  output logic                        err
);

  localparam int GID_W = $clog2(NUM_REQ);

`ifdef PIO_ARB_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, GAP, RDBK, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
`endif

  state_t              state_q, state_d;
  logic [GID_W-1:0]    rr_q, rr_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic [DATA_W-1:0]   byte_q, byte_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic                err_q, err_d;

  // Unpack the request bytes so the winner can be selected by index.
  logic [DATA_W-1:0] rd_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first set request strictly after rr_q, wrapping.
  logic             found;
  logic [GID_W-1:0] win;
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      automatic int idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && req[GID_W'(idx)]) begin
        found = 1'b1;
        win   = GID_W'(idx);
      end
    end
  end

`ifdef PIO_ARB_READBACK_EN
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              unused_rd_hi;
  assign unused_rd_hi = ^avm_readdata[31:DATA_W];
`else
  logic              unused_rd;
  assign unused_rd = ^avm_readdata;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
`ifdef PIO_ARB_READBACK_EN
    rb_d    = rb_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          rr_d    = win;
          gid_d   = win;
          byte_d  = rd_arr[win];
          state_d = WRITE;
        end
      end
`ifdef PIO_ARB_READBACK_EN
      WRITE: state_d = RDBK;
      RDBK: begin
        rb_d    = avm_readdata[DATA_W-1:0];
        state_d = CHECK;
      end
      CHECK: begin
`else
      WRITE: begin
`endif
        // End of a transfer: optional idle gap before re-arbitrating.
        if (HOLD_CYCLES > 0) begin
          cnt_d   = 8'(HOLD_CYCLES - 1);
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    busy_d = (state_d != IDLE);
    wn_d   = (state_d != WRITE);
    ack_d  = '0;
    err_d  = 1'b0;
`ifdef PIO_ARB_READBACK_EN
    cs_d   = (state_d == WRITE) || (state_d == RDBK);
    if (state_d == CHECK) begin
      ack_d = NUM_REQ'(1) << gid_d;
      err_d = (rb_d != byte_d);
    end
`else
    cs_d   = (state_d == WRITE);
    if (state_d == WRITE) ack_d = NUM_REQ'(1) << gid_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= GID_W'(NUM_REQ - 1);
      gid_q   <= GID_W'(NUM_REQ - 1);
      byte_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      err_q   <= 1'b0;
`ifdef PIO_ARB_READBACK_EN
      rb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      wn_q    <= wn_d;
      err_q   <= err_d;
`ifdef PIO_ARB_READBACK_EN
      rb_q    <= rb_d;
`endif
    end
  end

  assign ack            = ack_q;
  assign busy           = busy_q;
  assign grant_id       = gid_q;
  assign avm_address    = 2'b00;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = {{(32-DATA_W){1'b0}}, byte_q};
  assign err            = err_q;

endmodule
